jogo_memoria_parametrizado: RTL and testbench

Parametrised core of the memory-challenge game: replays a stored one-hot button sequence on `leds`, checks the player's button presses against it and appends one new entry per completed round, up to a configurable round count. It generalises button count, sequence depth, display timing and timeout length. It is the single sequential engine instantiated by the board top level, which adds only display decoding and pin mapping.

---
 rtl/jogo_memoria_parametrizado_if.sv | 27 ++
 rtl/jogo_memoria_parametrizado.sv | 232 +++++++++++++++++++++++
 tb/tb_jogo_memoria_parametrizado.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/jogo_memoria_parametrizado_if.sv
// rtl/jogo_memoria_parametrizado_if.sv - player, display and debug signal bundle of the memory game core
interface jogo_memoria_parametrizado_if #(
    parameter int NUM_BOTOES = 4,
    parameter int AW         = 4
);
    logic                  jogar;
    logic [1:0]            configuracao;
    logic [NUM_BOTOES-1:0] botoes;
    logic [NUM_BOTOES-1:0] leds;
    logic                  ganhou;
    logic                  perdeu;
    logic                  pronto;
    logic                  timeout;
    logic [3:0]            db_estado;
    logic [AW-1:0]         db_limite;
    logic [AW-1:0]         db_endereco;

    modport master (
        output jogar, configuracao, botoes,
        input  leds, ganhou, perdeu, pronto, timeout, db_estado, db_limite, db_endereco
    );

    modport slave (
        input  jogar, configuracao, botoes,
        output leds, ganhou, perdeu, pronto, timeout, db_estado, db_limite, db_endereco
    );
endinterface

// File: rtl/jogo_memoria_parametrizado.sv
// rtl/jogo_memoria_parametrizado.sv - memory game engine; GERADOR_ALEATORIO_EN selects LFSR-generated entries
module jogo_memoria_parametrizado #(
    parameter int  NUM_BOTOES   = 4,
    parameter int  PROFUNDIDADE = 16,
    parameter int  RODADAS_DEMO = 4,
    parameter int  T_LED        = 1000,
    parameter int  T_APAGADO    = 500,
    parameter int  T_TIMEOUT    = 5000,
    localparam int AW           = $clog2(PROFUNDIDADE)
) (
    input logic                         clock,
    input logic                         reset,
    jogo_memoria_parametrizado_if.slave s
);

    typedef enum logic [3:0] {
        INICIAL         = 4'h0,
        PREPARACAO      = 4'h1,
        INICIA_RODADA   = 4'h2,
        MOSTRA_LED      = 4'h3,
        PROXIMO_LED     = 4'h4,
        MOSTRA_APAGADO  = 4'h5,
        ESPERA_JOGADA   = 4'h7,
        REGISTRA        = 4'h8,
        COMPARA         = 4'h9,
        PROXIMA_JOGADA  = 4'hA,
        FINAL_ACERTO    = 4'hB,
        FINAL_ERRO      = 4'hC,
        ADICIONA_JOGADA = 4'hD,
        GRAVA           = 4'hE,
        FINAL_TIMEOUT   = 4'hF
    } estado_t;

    estado_t               estado;
    logic [31:0]           contador;
    logic [AW-1:0]         limite;
    logic [AW-1:0]         endereco;
    logic [NUM_BOTOES-1:0] jogada;
    logic [NUM_BOTOES-1:0] botoes_ant;
    logic                  modo_demo;
    logic                  timeout_en;
    logic                  ganhou_r;
    logic                  perdeu_r;
    logic                  pronto_r;
    logic                  timeout_r;
    logic [NUM_BOTOES-1:0] mem [PROFUNDIDADE];
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [NUM_BOTOES-1:0] mem_dado;
    logic [NUM_BOTOES-1:0] primeira_entrada;
    logic [AW-1:0]         ultima_rodada;
    logic                  jogada_feita;

    // A press is the first cycle with any button down after a cycle with none
    assign jogada_feita  = (s.botoes != '0) && (botoes_ant == '0);
    assign ultima_rodada = modo_demo ? AW'(RODADAS_DEMO - 1) : AW'(PROFUNDIDADE - 1);

`ifdef GERADOR_ALEATORIO_EN
    logic [15:0]           lfsr;
    logic [NUM_BOTOES-1:0] sorteio;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign sorteio          = NUM_BOTOES'(1) << (32'(lfsr) % 32'(NUM_BOTOES));
    assign primeira_entrada = sorteio;
`else
    assign primeira_entrada = NUM_BOTOES'(1);
`endif

    // Previous-cycle button image for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) botoes_ant <= '0;
        else       botoes_ant <= s.botoes;
    end

    // Sequence memory write port: first entry in preparacao, new entry in grava
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_dado = '0;
        if (estado == PREPARACAO) begin
            mem_we   = 1'b1;
            mem_dado = primeira_entrada;
        end else if (estado == GRAVA) begin
            mem_we   = 1'b1;
            mem_addr = limite + AW'(1);
            mem_dado = jogada;
        end
    end

    // Sequence storage; contents survive reset since every game rewrites entry 0 first
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_dado;
    end

    // Game sequencer: replay, compare, extend, and result flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= INICIAL;
            contador   <= '0;
            limite     <= '0;
            endereco   <= '0;
            jogada     <= '0;
            modo_demo  <= 1'b0;
            timeout_en <= 1'b0;
            ganhou_r   <= 1'b0;
            perdeu_r   <= 1'b0;
            pronto_r   <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            case (estado)
                INICIAL: if (s.jogar) estado <= PREPARACAO;
                PREPARACAO: begin
                    modo_demo  <= s.configuracao[0];
                    timeout_en <= s.configuracao[1];
                    limite     <= '0;
                    ganhou_r   <= 1'b0;
                    perdeu_r   <= 1'b0;
                    pronto_r   <= 1'b0;
                    timeout_r  <= 1'b0;
                    estado     <= INICIA_RODADA;
                end
                INICIA_RODADA: begin
                    endereco <= '0;
                    contador <= '0;
                    estado   <= MOSTRA_LED;
                end
                MOSTRA_LED: begin
                    if (contador == 32'(T_LED - 1)) begin
                        contador <= '0;
                        estado   <= MOSTRA_APAGADO;
                    end else begin
                        contador <= contador + 32'd1;
                    end
                end
                MOSTRA_APAGADO: begin
                    if (contador == 32'(T_APAGADO - 1)) begin
                        contador <= '0;
                        if (endereco == limite) begin
                            endereco <= '0;
                            estado   <= ESPERA_JOGADA;
                        end else begin
                            estado <= PROXIMO_LED;
                        end
                    end else begin
                        contador <= contador + 32'd1;
                    end
                end
                PROXIMO_LED: begin
                    endereco <= endereco + AW'(1);
                    estado   <= MOSTRA_LED;
                end
                ESPERA_JOGADA: begin
                    if (jogada_feita) begin
                        estado <= REGISTRA;
                    end else if (timeout_en && contador == 32'(T_TIMEOUT - 1)) begin
                        perdeu_r  <= 1'b1;
                        timeout_r <= 1'b1;
                        pronto_r  <= 1'b1;
                        estado    <= FINAL_TIMEOUT;
                    end else if (timeout_en) begin
                        contador <= contador + 32'd1;
                    end
                end
                REGISTRA: begin
                    jogada <= s.botoes;
                    estado <= COMPARA;
                end
                COMPARA: begin
                    if (jogada != mem[endereco]) begin
                        perdeu_r <= 1'b1;
                        pronto_r <= 1'b1;
                        estado   <= FINAL_ERRO;
                    end else if (endereco != limite) begin
                        estado <= PROXIMA_JOGADA;
                    end else if (limite == ultima_rodada) begin
                        ganhou_r <= 1'b1;
                        pronto_r <= 1'b1;
                        estado   <= FINAL_ACERTO;
                    end else begin
                        estado <= ADICIONA_JOGADA;
                    end
                end
                PROXIMA_JOGADA: begin
                    endereco <= endereco + AW'(1);
                    contador <= '0;
                    estado   <= ESPERA_JOGADA;
                end
                ADICIONA_JOGADA: begin
`ifdef GERADOR_ALEATORIO_EN
                    jogada <= sorteio;
                    estado <= GRAVA;
`else
                    if (jogada_feita && $onehot(s.botoes)) begin
                        jogada <= s.botoes;
                        estado <= GRAVA;
                    end
`endif
                end
                GRAVA: begin
                    limite <= limite + AW'(1);
                    estado <= INICIA_RODADA;
                end
                FINAL_ACERTO, FINAL_ERRO, FINAL_TIMEOUT: if (s.jogar) estado <= PREPARACAO;
                default: estado <= INICIAL;
            endcase
        end
    end

    // LED drive: stored entry while lit, live buttons while waiting for the player
    always_comb begin
        s.leds = '0;
        case (estado)
            MOSTRA_LED:                     s.leds = mem[endereco];
            ESPERA_JOGADA, ADICIONA_JOGADA: s.leds = s.botoes;
            default:                        s.leds = '0;
        endcase
    end

    assign s.ganhou      = ganhou_r;
    assign s.perdeu      = perdeu_r;
    assign s.pronto      = pronto_r;
    assign s.timeout     = timeout_r;
    assign s.db_estado   = estado;
    assign s.db_limite   = limite;
    assign s.db_endereco = endereco;

endmodule

// File: tb/tb_jogo_memoria_parametrizado.sv
// tb/tb_jogo_memoria_parametrizado.sv - scoreboard bench for the memory game core
module tb_jogo_memoria_parametrizado;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    jogo_memoria_parametrizado_if #(.NUM_BOTOES(4), .AW(4)) bus ();

    jogo_memoria_parametrizado #(
        .NUM_BOTOES  (4),
        .PROFUNDIDADE(16),
        .RODADAS_DEMO(4),
        .T_LED       (5),
        .T_APAGADO   (3),
        .T_TIMEOUT   (20)
    ) dut (
        .clock(clk),
        .reset(rst),
        .s    (bus)
    );

    typedef struct packed {
        logic [3:0] estado;
        logic       ganhou;
        logic       perdeu;
        logic       timeout;
        logic [3:0] limite;
    } resultado_t;

    logic [3:0] led_q [$];
    resultado_t res_q [$];
    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] seq [4];
    logic [3:0] estado_ant = 4'h0;
    logic       pronto_ant = 1'b0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        vectors++;
        if (atual !== esperado) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] alvo, input int budget, input string nome);
        bit achou = 1'b0;
        for (int i = 0; i < budget && !achou; i++) begin
            @(negedge clk);
            if (bus.db_estado == alvo) achou = 1'b1;
        end
        if (!achou) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: state %0h not reached, got %0h", nome, alvo, bus.db_estado);
        end
    endtask

    task automatic press(input logic [3:0] v);
        tick();
        bus.botoes = v;
        repeat (2) tick();
        bus.botoes = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic pulse_jogar();
        tick();
        bus.jogar = 1'b1;
        tick();
        bus.jogar = 1'b0;
    endtask

    task automatic push_replay(input int ultimo);
        for (int i = 0; i <= ultimo; i++) led_q.push_back(seq[i]);
    endtask

    // Monitor: each new LED in replay and each rising pronto is checked against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.db_estado == 4'h3 && estado_ant != 4'h3) begin
                vectors++;
                if (led_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL replay_led: unexpected led %b", bus.leds);
                end else begin
                    logic [3:0] e;
                    e = led_q.pop_front();
                    if (bus.leds !== e) begin
                        miscompares++;
                        $display("FAIL replay_led: got %b expected %b", bus.leds, e);
                    end
                end
            end
            if (bus.pronto && !pronto_ant) begin
                resultado_t a;
                a = '{bus.db_estado, bus.ganhou, bus.perdeu, bus.timeout, bus.db_limite};
                vectors++;
                if (res_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL result: unexpected result %h", a);
                end else begin
                    resultado_t e;
                    e = res_q.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL result: got %h expected %h", a, e);
                    end
                end
            end
        end
        estado_ant = bus.db_estado;
        pronto_ant = bus.pronto;
    end

    initial begin
        seq[0] = 4'b0001;
        seq[1] = 4'b0010;
        seq[2] = 4'b0100;
        seq[3] = 4'b1000;
        bus.jogar        = 1'b0;
        bus.configuracao = 2'b00;
        bus.botoes       = 4'b0000;
        repeat (3) tick();
        check("reset_estado", 32'(bus.db_estado), 32'h0);
        check("reset_leds", 32'(bus.leds), 32'h0);
        check("reset_flags", 32'({bus.ganhou, bus.perdeu, bus.pronto, bus.timeout}), 32'h0);
        check("reset_limite", 32'(bus.db_limite), 32'h0);
        check("reset_endereco", 32'(bus.db_endereco), 32'h0);
        rst = 1'b0;

        // Demo win over four rounds
        bus.configuracao = 2'b01;
        push_replay(0);
        res_q.push_back('{4'hB, 1'b1, 1'b0, 1'b0, 4'd3});
        pulse_jogar();
        for (int r = 0; r < 4; r++) begin
            wait_state(4'h7, 200, "demo_wait_play");
            for (int i = 0; i <= r; i++) press(seq[i]);
            if (r < 3) begin
                wait_state(4'hD, 20, "demo_wait_add");
                push_replay(r + 1);
                press(seq[r + 1]);
            end
        end
        wait_state(4'hB, 20, "demo_win");
        check("demo_limite", 32'(bus.db_limite), 32'd3);

        // Wrong press: error state three cycles after the press edge
        push_replay(0);
        res_q.push_back('{4'hC, 1'b0, 1'b1, 1'b0, 4'd0});
        pulse_jogar();
        wait_state(4'h7, 100, "err_wait_play");
        tick();
        bus.botoes = 4'b1000;
        repeat (3) tick();
        check("err_latency_state", 32'(bus.db_estado), 32'hC);
        bus.botoes = 4'b0000;
        repeat (2) tick();

        // Timeout: final_timeout exactly 20 cycles after entering espera_jogada
        bus.configuracao = 2'b11;
        push_replay(0);
        res_q.push_back('{4'hF, 1'b0, 1'b1, 1'b1, 4'd0});
        pulse_jogar();
        wait_state(4'h7, 100, "to_wait_play");
        repeat (19) @(negedge clk);
        check("to_still_waiting", 32'(bus.db_estado), 32'h7);
        @(negedge clk);
        check("to_fired", 32'(bus.db_estado), 32'hF);

        // Held button counts once; multi-hot ignored while adding
        bus.configuracao = 2'b00;
        push_replay(0);
        pulse_jogar();
        wait_state(4'h7, 100, "held_wait_play");
        tick();
        bus.botoes = 4'b0001;
        repeat (50) tick();
        check("held_once", 32'(bus.db_estado), 32'hD);
        bus.botoes = 4'b0000;
        repeat (3) tick();
        press(4'b0011);
        check("multihot_ignored", 32'(bus.db_estado), 32'hD);
        led_q.push_back(4'b0001);
        led_q.push_back(4'b0100);
        press(4'b0100);
        wait_state(4'h7, 200, "mh_wait_play");
        press(4'b0001);
        press(4'b0100);
        wait_state(4'hD, 20, "mh_round2_add");
        check("mh_limite", 32'(bus.db_limite), 32'd1);

        // Reset during replay, then a fresh game shows only the first entry
        led_q.push_back(4'b0001);
        press(4'b1000);
        wait_state(4'h3, 20, "rst_wait_replay");
        #2;
        rst = 1'b1;
        #1;
        check("rst_estado", 32'(bus.db_estado), 32'h0);
        check("rst_leds", 32'(bus.leds), 32'h0);
        check("rst_flags_limite", 32'({bus.ganhou, bus.perdeu, bus.pronto, bus.timeout, bus.db_limite}), 32'h0);
        tick();
        rst = 1'b0;
        push_replay(0);
        pulse_jogar();
        wait_state(4'h7, 100, "post_rst_wait_play");
        check("post_rst_limite", 32'(bus.db_limite), 32'd0);

        repeat (2) tick();
        check("led_queue_empty", 32'(led_q.size()), 32'd0);
        check("res_queue_empty", 32'(res_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
